// File: rtl/lfsr8_checker.sv
// lfsr8_checker: self-synchronising PRBS receiver for the LFSR8 stream (seed, track, lock, count errors).
// Optional compared-bit counter on BIT_COUNT is built only when HDSISO8_CHK_BITCNT_EN is defined.
module lfsr8_checker #(
  parameter logic [7:0]  TAPS       = 8'b10111000,
  parameter int unsigned LOCK_MATCH = 16,
  parameter int unsigned WIN_LEN    = 32,
  parameter int unsigned LOSS_ERR   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BIT_EN,
  input  logic        BIT_IN,
  input  logic        CLR_CNT,
  output logic        LOCK,
  output logic        ERR_PULSE,
  output logic [7:0]  ERR_COUNT,
  output logic [1:0]  STATE,
  output logic [15:0] BIT_COUNT
);

  localparam logic [7:0] LOCK_MATCH_V = 8'(LOCK_MATCH);
  localparam logic [7:0] WIN_LEN_V    = 8'(WIN_LEN);
  localparam logic [7:0] LOSS_ERR_V   = 8'(LOSS_ERR);

  typedef enum logic [1:0] {
    SEED   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] sreg, sreg_nxt;
  logic [2:0] seed_cnt, seed_nxt;
  logic [7:0] match_cnt, match_nxt;
  logic [7:0] win_cnt, win_nxt;
  logic [7:0] win_err, win_err_nxt;
  logic       pred;
  logic       mismatch;
  logic       err_hit;

  assign pred     = ^(sreg & TAPS);
  assign mismatch = BIT_IN ^ pred;
  assign err_hit  = BIT_EN && (state == LOCKED) && mismatch;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    seed_nxt    = seed_cnt;
    match_nxt   = match_cnt;
    win_nxt     = win_cnt;
    win_err_nxt = win_err;
    if (BIT_EN) begin
      case (state)
        SEED: begin
          sreg_nxt = {sreg[6:0], BIT_IN};
          seed_nxt = seed_cnt + 3'd1;
          // An all-zero register is the LFSR lockup state; wrap and seed again.
          if (seed_cnt == 3'd7 && sreg_nxt != 8'h00) begin
            state_nxt = TRACK;
            match_nxt = '0;
          end
        end
        TRACK: begin
          sreg_nxt = {sreg[6:0], BIT_IN};
          if (!mismatch) begin
            match_nxt = match_cnt + 8'd1;
            if (match_nxt == LOCK_MATCH_V) begin
              state_nxt   = LOCKED;
              win_nxt     = '0;
              win_err_nxt = '0;
            end
          end else begin
            state_nxt = SEED;
            seed_nxt  = '0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so a corrupted bit cannot poison the register.
          sreg_nxt    = {sreg[6:0], pred};
          win_nxt     = win_cnt + 8'd1;
          win_err_nxt = win_err + {7'd0, mismatch};
          if (win_err_nxt >= LOSS_ERR_V) begin
            state_nxt   = SEED;
            seed_nxt    = '0;
            win_nxt     = '0;
            win_err_nxt = '0;
          end else if (win_nxt == WIN_LEN_V) begin
            win_nxt     = '0;
            win_err_nxt = '0;
          end
        end
        default: begin
          state_nxt = SEED;
          seed_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= SEED;
      sreg      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      LOCK      <= 1'b0;
      ERR_PULSE <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      win_cnt   <= win_nxt;
      win_err   <= win_err_nxt;
      LOCK      <= (state_nxt == LOCKED);
      ERR_PULSE <= err_hit;
      if (CLR_CNT) begin
        ERR_COUNT <= '0;
      end else if (err_hit && ERR_COUNT != 8'hFF) begin
        ERR_COUNT <= ERR_COUNT + 8'd1;
      end
    end
  end

  assign STATE = state;

`ifdef HDSISO8_CHK_BITCNT_EN
  logic [15:0] bit_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt <= '0;
    end else if (CLR_CNT) begin
      bit_cnt <= '0;
    end else if (BIT_EN && state == LOCKED && bit_cnt != 16'hFFFF) begin
      bit_cnt <= bit_cnt + 16'd1;
    end
  end

  assign BIT_COUNT = bit_cnt;
`else
  assign BIT_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr8_checker.sv
// Self-checking bench for lfsr8_checker: an abstract behavioural model compared every cycle plus directed literal checks.
module tb_lfsr8_checker;

  localparam int LOCK_MATCH = 16;
  localparam int WIN_LEN    = 32;
  localparam int LOSS_ERR   = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BIT_EN;
  logic        BIT_IN;
  logic        CLR_CNT;
  logic        LOCK;
  logic        ERR_PULSE;
  logic [7:0]  ERR_COUNT;
  logic [1:0]  STATE;
  logic [15:0] BIT_COUNT;

  lfsr8_checker dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BIT_EN    (BIT_EN),
    .BIT_IN    (BIT_IN),
    .CLR_CNT   (CLR_CNT),
    .LOCK      (LOCK),
    .ERR_PULSE (ERR_PULSE),
    .ERR_COUNT (ERR_COUNT),
    .STATE     (STATE),
    .BIT_COUNT (BIT_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Generator: the LFSR stream as a list of bits, seed 8'h01 emitted MSB first,
  // then s[n] = s[n-8] ^ s[n-6] ^ s[n-5] ^ s[n-4].
  bit gstream[$];

  function automatic bit gen_next();
    logic [7:0] seed_v = 8'h01;
    int n = gstream.size();
    bit b;
    if (n < 8) b = seed_v[7-n];
    else       b = gstream[n-8] ^ gstream[n-6] ^ gstream[n-5] ^ gstream[n-4];
    gstream.push_back(b);
    return b;
  endfunction

  // Behavioural model: mode 0 seed, 1 track, 2 locked; hist holds the last 8 bits, newest last.
  bit hist[$];
  int m_mode, m_seed, m_match, m_win, m_werr, m_errs, m_bits, m_pulse, m_lock;

  function automatic bit model_pred();
    logic [7:0] t = 8'b10111000;
    bit p = 1'b0;
    for (int k = 0; k < 8; k++)
      if (t[k]) p ^= hist[7-k];
    return p;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
    m_mode = 0; m_seed = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_errs = 0; m_bits = 0; m_pulse = 0; m_lock = 0;
  endfunction

  function automatic void model_push(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction

  function automatic void model_step(input bit en, input bit b, input bit clr);
    bit p;
    int ones;
    m_pulse = 0;
    if (en) begin
      p = model_pred();
      if (m_mode == 0) begin
        model_push(b);
        m_seed++;
        if (m_seed == 8) begin
          m_seed = 0;
          ones = 0;
          foreach (hist[i]) ones += int'(hist[i]);
          if (ones != 0) begin m_mode = 1; m_match = 0; end
        end
      end else if (m_mode == 1) begin
        model_push(b);
        if (b == p) begin
          m_match++;
          if (m_match == LOCK_MATCH) begin m_mode = 2; m_win = 0; m_werr = 0; end
        end else begin
          m_mode = 0; m_seed = 0;
        end
      end else begin
        model_push(p);
        if (m_bits < 65535) m_bits++;
        m_win++;
        if (b != p) begin
          m_pulse = 1;
          if (m_errs < 255) m_errs++;
          m_werr++;
        end
        if (m_werr >= LOSS_ERR) begin
          m_mode = 0; m_seed = 0; m_win = 0; m_werr = 0;
        end else if (m_win == WIN_LEN) begin
          m_win = 0; m_werr = 0;
        end
      end
    end
    if (clr) begin m_errs = 0; m_bits = 0; end
    m_lock = (m_mode == 2) ? 1 : 0;
  endfunction

  function automatic int exp_bits();
`ifdef HDSISO8_CHK_BITCNT_EN
    return m_bits;
`else
    return 0;
`endif
  endfunction

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cyc_lock",      int'(LOCK),      m_lock);
      check("cyc_err_pulse", int'(ERR_PULSE), m_pulse);
      check("cyc_err_count", int'(ERR_COUNT), m_errs);
      check("cyc_state",     int'(STATE),     m_mode);
      check("cyc_bit_count", int'(BIT_COUNT), exp_bits());
    end
  end

  task automatic send(input bit en, input bit b, input bit clr);
    BIT_EN  = en;
    BIT_IN  = b;
    CLR_CNT = clr;
    @(posedge CLK);
    model_step(en, b, clr);
    #1;
    BIT_EN  = 1'b0;
    CLR_CNT = 1'b0;
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) send(1'b1, gen_next(), 1'b0);
  endtask

  task automatic bad();
    send(1'b1, ~gen_next(), 1'b0);
  endtask

  // Called just after a rising edge; RESET is pulled low between edges.
  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    gstream.delete();
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    RESET   = 1'b0;
    BIT_EN  = 1'b0;
    BIT_IN  = 1'b0;
    CLR_CNT = 1'b0;
    model_reset();
    #3;
    check("rst_lock",      int'(LOCK),      0);
    check("rst_err_pulse", int'(ERR_PULSE), 0);
    check("rst_err_count", int'(ERR_COUNT), 0);
    check("rst_state",     int'(STATE),     0);
    check("rst_bit_count", int'(BIT_COUNT), 0);
    #9;
    RESET  = 1'b1;
    cmp_en = 1'b1;

    // Acquire: 8 seed bits then 16 matches.
    good(7);
    check("seed_state_7", int'(STATE), 0);
    good(1);
    check("track_state_8", int'(STATE), 1);
    good(15);
    check("lock_low_23", int'(LOCK), 0);
    good(1);
    check("lock_high_24", int'(LOCK), 1);
    check("lock_state_24", int'(STATE), 2);
    check("lock_errs_24", int'(ERR_COUNT), 0);

    // Single inverted bit with idle gaps around it.
    good(5);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    bad();
    check("single_pulse", int'(ERR_PULSE), 1);
    check("single_errs", int'(ERR_COUNT), 1);
    good(1);
    check("single_pulse_off", int'(ERR_PULSE), 0);
    good(20);
    check("single_errs_after", int'(ERR_COUNT), 1);
    check("single_lock_kept", int'(LOCK), 1);

    // Loss of lock: 4 errors in one window, then re-acquire.
    do_reset();
    good(24);
    bad(); good(1); bad(); good(1); bad(); good(1);
    check("loss_lock_3err", int'(LOCK), 1);
    bad();
    check("loss_lock", int'(LOCK), 0);
    check("loss_state", int'(STATE), 0);
    check("loss_errs", int'(ERR_COUNT), 4);
    good(23);
    check("relock_low", int'(LOCK), 0);
    good(1);
    check("relock_high", int'(LOCK), 1);

    // All-zero input never leaves SEED.
    do_reset();
    for (int i = 0; i < 40; i++) send(1'b1, 1'b0, 1'b0);
    check("zero_state", int'(STATE), 0);
    check("zero_lock", int'(LOCK), 0);

    // Saturation: 3 errors per window for 100 windows.
    do_reset();
    good(24);
    for (int w = 0; w < 100; w++)
      for (int p = 0; p < WIN_LEN; p++)
        if (p < 3) bad(); else good(1);
    check("sat_errs", int'(ERR_COUNT), 255);
    check("sat_lock", int'(LOCK), 1);
    send(1'b1, ~gen_next(), 1'b1);
    check("clr_errs", int'(ERR_COUNT), 0);
    check("clr_pulse", int'(ERR_PULSE), 1);
    good(4);

    // Compared-bit counter, then reset mid-stream.
    do_reset();
    good(24);
    good(1000);
`ifdef HDSISO8_CHK_BITCNT_EN
    check("bitcnt_1000", int'(BIT_COUNT), 1000);
`else
    check("bitcnt_tied", int'(BIT_COUNT), 0);
`endif
    good(7);
    RESET = 1'b0;
    model_reset();
    #1;
    check("mid_rst_lock",      int'(LOCK),      0);
    check("mid_rst_state",     int'(STATE),     0);
    check("mid_rst_err_count", int'(ERR_COUNT), 0);
    check("mid_rst_pulse",     int'(ERR_PULSE), 0);
    check("mid_rst_bit_count", int'(BIT_COUNT), 0);
    #1;
    RESET = 1'b1;
    gstream.delete();
    good(30);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
